msk_rx_acq_ctrl: RTL
====================

Name: msk_rx_acq_ctrl

Overview:
Acquisition/tracking sequencer for the MSK receive chain (DDC -> matched filter -> Gardner TED/PI loop/phase accumulator -> polyphase interp -> slicer).
- Enables coarse CFO estimation after the timing loop settles and captures its frequency word.
- Qualifies timing lock from the TED error stream and gates slicer data to downstream.
- Detects loss of lock and re-acquires.

Parameters:
WERR, 18, width of signed TED error ek_i
FW, 24, width of CFO frequency word
CW, 16, width of internal symbol/sample counters
SETTLE_SYMS, 64, symbols to wait in SETTLE before enabling CFO
CFO_TIMEOUT, 1024, max symbols in CFO state before FAIL
VERIFY_TIMEOUT, 2048, max symbols in VERIFY before FAIL
LOCK_THR, 2048, |ek| strictly below this counts as good
LOCK_CNT, 32, consecutive good ek samples to declare lock
UNLOCK_CNT, 16, consecutive bad ek samples in TRACK to declare loss

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start_i  in  1  level; acquisition begins when high in IDLE
abort_i  in  1  pulse; forces IDLE
sym_val_i  in  1  one strobe per recovered symbol (interp sym valid)
ek_i  in  WERR  signed Gardner error
ek_val_i  in  1  ek_i valid strobe
cfo_done_i  in  1  1-clk pulse from coarse CFO estimator
cfo_word_i  in  FW  coarse CFO word, valid with cfo_done_i
cfo_en_o  out  1  enable to coarse CFO estimator
lf_hold_o  out  1  freeze PI loop-filter integrator
cfo_word_o  out  FW  captured CFO word
cfo_word_val_o  out  1  1-clk pulse on capture
lock_o  out  1  timing lock qualified
data_en_o  out  1  gate for slicer data valid
acq_fail_o  out  1  1-clk pulse on timeout
lock_lost_o  out  1  1-clk pulse on loss of lock
state_o  out  3  current state encoding

Behaviour:
- All outputs registered. Any decision takes effect on the cycle after the triggering input.
- Reset: state IDLE (0). All outputs 0, cfo_word_o = 0. Counters cleared.
- States and transitions:
  - IDLE (0): counters cleared. start_i=1 -> SETTLE.
  - SETTLE (1): count sym_val_i. Count == SETTLE_SYMS -> CFO, clear count.
  - CFO (2):
    - cfo_en_o=1 and lf_hold_o=1 for the whole state.
    - cfo_done_i -> latch cfo_word_i into cfo_word_o, pulse cfo_word_val_o, go to VERIFY.
    - Otherwise symbol count == CFO_TIMEOUT -> FAIL.
    - cfo_done_i on the same cycle as timeout: done wins.
  - VERIFY (3):
    - Each ek_val_i: |ek_i| < LOCK_THR increments good_cnt (saturating at LOCK_CNT); else good_cnt = 0.
    - good_cnt reaching LOCK_CNT -> TRACK.
    - Symbol count == VERIFY_TIMEOUT -> FAIL. Lock wins if both occur on the same cycle.
  - TRACK (4):
    - lock_o=1 and data_en_o=1.
    - Each ek_val_i: |ek_i| >= LOCK_THR increments bad_cnt; a good sample clears it.
    - bad_cnt reaching UNLOCK_CNT -> pulse lock_lost_o, go to SETTLE. lock_o/data_en_o drop on that transition. cfo_word_o is held.
  - FAIL (5): acq_fail_o=1 for exactly one cycle, then IDLE. Retries from IDLE if start_i is still high.
- |ek| computation: two's-complement magnitude saturated to 2^(WERR-1)-1 for the most-negative input, so it is always bad for LOCK_THR <= 2^(WERR-1)-1.
- sym_val_i and ek_val_i are independent and may coincide; both are processed in the same cycle.
- Counters compare with == and never wrap. Each counter is cleared on state entry.
- abort_i:
  - In any state -> IDLE next cycle, with priority over every transition except rst.
  - All pulses are suppressed on that cycle; outputs return to IDLE values.
  - cfo_word_o is retained.
- rst mid-operation: identical to power-up reset; cfo_word_o is cleared.
- start_i deasserting outside IDLE has no effect; only abort_i stops the sequence.
- Encodings 6-7 are unreachable; a recovery path returns them to IDLE.

Test Plan:
1. rst 4 clks, start_i=1, sym_val_i every 20 clks -> SETTLE for 64 symbols; cfo_en_o/lf_hold_o rise the cycle after the 64th strobe; state_o=2.
2. In CFO, pulse cfo_done_i with cfo_word_i=0x12_3456 -> cfo_word_o=0x123456, cfo_word_val_o single pulse, state_o=3, cfo_en_o=0.
3. VERIFY: 31 good ek (|ek|=100), one ek=-2048, then 32 good -> lock_o rises exactly after the 32nd post-reset-of-count good sample; ek=-131072 is treated as bad.
4. TRACK: 15 bad ek (3000) + 1 good + 16 bad -> lock_lost_o pulses only after the final 16th bad, state_o=1, data_en_o=0, cfo_word_o unchanged.
5. Hold cfo_done_i low -> after 1024 symbols acq_fail_o pulses 1 clk, state returns 0 then re-enters 1 with start_i high.
6. abort_i asserted mid-VERIFY coincident with the lock-completing good sample -> state_o=0 next cycle, no lock_o, no pulses; rst in TRACK -> all outputs 0 next cycle.

Source files
------------

// File: rtl/msk_rx_acq_ctrl.sv
// MSK receive acquisition/tracking sequencer: settle -> coarse CFO -> lock verify -> track.
// Every output is registered and changes one cycle after its trigger. There is no backpressure: all strobes are consumed when they arrive.
module msk_rx_acq_ctrl #(
  parameter int WERR           = 18,
  parameter int FW             = 24,
  parameter int CW             = 16,
  parameter int SETTLE_SYMS    = 64,
  parameter int CFO_TIMEOUT    = 1024,
  parameter int VERIFY_TIMEOUT = 2048,
  parameter int LOCK_THR       = 2048,
  parameter int LOCK_CNT       = 32,
  parameter int UNLOCK_CNT     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic                   sym_val_i,
  input  logic signed [WERR-1:0] ek_i,
  input  logic                   ek_val_i,
  input  logic                   cfo_done_i,
  input  logic [FW-1:0]          cfo_word_i,
  output logic                   cfo_en_o,
  output logic                   lf_hold_o,
  output logic [FW-1:0]          cfo_word_o,
  output logic                   cfo_word_val_o,
  output logic                   lock_o,
  output logic                   data_en_o,
  output logic                   acq_fail_o,
  output logic                   lock_lost_o,
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_CFO    = 3'd2,
    S_VERIFY = 3'd3,
    S_TRACK  = 3'd4,
    S_FAIL   = 3'd5
  } state_t;

  // Counters are compared against "limit - 1" because the hit is detected on
  // the strobe that would make the count equal the limit.
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_SYMS - 1);
  localparam logic [CW-1:0] CFO_LAST    = CW'(CFO_TIMEOUT - 1);
  localparam logic [CW-1:0] VERIFY_LAST = CW'(VERIFY_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_CNT - 1);
  localparam logic [CW-1:0] LOCK_SAT    = CW'(LOCK_CNT);
  localparam logic [CW-1:0] UNLOCK_LAST = CW'(UNLOCK_CNT - 1);
  localparam logic [31:0]   THR         = 32'(LOCK_THR);
  localparam logic [WERR-1:0] EK_MIN    = {1'b1, {(WERR-1){1'b0}}};
  localparam logic [WERR-1:0] MAG_MAX   = {1'b0, {(WERR-1){1'b1}}};

  state_t          state;
  logic [CW-1:0]   sym_cnt;
  logic [CW-1:0]   good_cnt;
  logic [CW-1:0]   bad_cnt;
  logic [WERR-1:0] ek_mag;
  logic            ek_good;
  logic            settle_hit;
  logic            cfo_timeout;
  logic            verify_timeout;
  logic            lock_hit;
  logic            unlock_hit;

  // The most-negative error has no positive twin; saturate so it reads as bad.
  always_comb begin
    ek_mag = ek_i[WERR-1] ? WERR'(-ek_i) : WERR'(ek_i);
    if (ek_i == EK_MIN) begin
      ek_mag = MAG_MAX;
    end
  end

  assign ek_good        = ({{(32-WERR){1'b0}}, ek_mag} < THR);
  assign settle_hit     = sym_val_i && (sym_cnt == SETTLE_LAST);
  assign cfo_timeout    = sym_val_i && (sym_cnt == CFO_LAST);
  assign verify_timeout = sym_val_i && (sym_cnt == VERIFY_LAST);
  assign lock_hit       = ek_val_i && ek_good && (good_cnt == LOCK_LAST);
  assign unlock_hit     = ek_val_i && !ek_good && (bad_cnt == UNLOCK_LAST);
  assign state_o        = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      sym_cnt        <= '0;
      good_cnt       <= '0;
      bad_cnt        <= '0;
      cfo_en_o       <= 1'b0;
      lf_hold_o      <= 1'b0;
      cfo_word_o     <= '0;
      cfo_word_val_o <= 1'b0;
      lock_o         <= 1'b0;
      data_en_o      <= 1'b0;
      acq_fail_o     <= 1'b0;
      lock_lost_o    <= 1'b0;
    end else begin
      cfo_word_val_o <= 1'b0;
      acq_fail_o     <= 1'b0;
      lock_lost_o    <= 1'b0;

      if (abort_i) begin
        // cfo_word_o deliberately survives an abort.
        state     <= S_IDLE;
        sym_cnt   <= '0;
        good_cnt  <= '0;
        bad_cnt   <= '0;
        cfo_en_o  <= 1'b0;
        lf_hold_o <= 1'b0;
        lock_o    <= 1'b0;
        data_en_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            sym_cnt  <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
            if (start_i) begin
              state <= S_SETTLE;
            end
          end

          S_SETTLE: begin
            if (settle_hit) begin
              state     <= S_CFO;
              sym_cnt   <= '0;
              cfo_en_o  <= 1'b1;
              lf_hold_o <= 1'b1;
            end else if (sym_val_i) begin
              sym_cnt <= sym_cnt + 1'b1;
            end
          end

          S_CFO: begin
            if (cfo_done_i) begin
              state          <= S_VERIFY;
              sym_cnt        <= '0;
              good_cnt       <= '0;
              cfo_word_o     <= cfo_word_i;
              cfo_word_val_o <= 1'b1;
              cfo_en_o       <= 1'b0;
              lf_hold_o      <= 1'b0;
            end else if (cfo_timeout) begin
              state      <= S_FAIL;
              sym_cnt    <= '0;
              acq_fail_o <= 1'b1;
              cfo_en_o   <= 1'b0;
              lf_hold_o  <= 1'b0;
            end else if (sym_val_i) begin
              sym_cnt <= sym_cnt + 1'b1;
            end
          end

          S_VERIFY: begin
            if (lock_hit) begin
              state     <= S_TRACK;
              sym_cnt   <= '0;
              good_cnt  <= '0;
              bad_cnt   <= '0;
              lock_o    <= 1'b1;
              data_en_o <= 1'b1;
            end else if (verify_timeout) begin
              state      <= S_FAIL;
              sym_cnt    <= '0;
              good_cnt   <= '0;
              acq_fail_o <= 1'b1;
            end else begin
              if (sym_val_i) begin
                sym_cnt <= sym_cnt + 1'b1;
              end
              if (ek_val_i) begin
                if (!ek_good) begin
                  good_cnt <= '0;
                end else if (good_cnt != LOCK_SAT) begin
                  good_cnt <= good_cnt + 1'b1;
                end
              end
            end
          end

          S_TRACK: begin
            if (unlock_hit) begin
              state       <= S_SETTLE;
              sym_cnt     <= '0;
              bad_cnt     <= '0;
              lock_lost_o <= 1'b1;
              lock_o      <= 1'b0;
              data_en_o   <= 1'b0;
            end else if (ek_val_i) begin
              bad_cnt <= ek_good ? '0 : bad_cnt + 1'b1;
            end
          end

          S_FAIL: begin
            state    <= S_IDLE;
            sym_cnt  <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
          end

          default: begin
            // Encodings 6-7 cannot be entered; fall back to a clean IDLE.
            state     <= S_IDLE;
            sym_cnt   <= '0;
            good_cnt  <= '0;
            bad_cnt   <= '0;
            cfo_en_o  <= 1'b0;
            lf_hold_o <= 1'b0;
            lock_o    <= 1'b0;
            data_en_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
